// File: rtl/dht11_poll_sched.sv
`default_nettype none
// ============================================================================
//  Module   : dht11_poll_sched
//  Purpose  : Poll scheduler for the top_dht11 sensor core. Issues one-cycle
//             trigger pulses on manual request or on a periodic auto timer,
//             keeps the minimum gap between sensor transactions, collects the
//             humidity/temperature words, retries failed reads and publishes
//             validated results.
//  Ports    : clk, rst        - clock, asynchronous active-high reset
//             i_start         - one-cycle manual poll request
//             i_auto          - level, periodic polling enable
//             o_en            - one-cycle trigger to the sensor core
//             i_busy, i_conv, i_value, i_err - sensor core status/data
//             o_hum, o_temp   - last good humidity / temperature words
//             o_valid, o_fail - result pulses (success / retries exhausted)
//             o_busy          - transaction in progress
//             o_err_cnt       - saturating count of failed attempts
//  Revision : 1.0 - initial release
// ============================================================================
module dht11_poll_sched #(
    parameter int unsigned VALUE_SZ   = 16,
    parameter int unsigned GAP_CYC    = 50_000_000,
    parameter int unsigned PERIOD_CYC = 100_000_000,
    parameter int unsigned BUSY_TO    = 10_000,
    parameter int unsigned MAX_RETRY  = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic                i_auto,
    output logic                o_en,
    input  logic                i_busy,
    input  logic                i_conv,
    input  logic [VALUE_SZ-1:0] i_value,
    input  logic                i_err,
    output logic [VALUE_SZ-1:0] o_hum,
    output logic [VALUE_SZ-1:0] o_temp,
    output logic                o_valid,
    output logic                o_fail,
    output logic                o_busy,
    output logic [7:0]          o_err_cnt
);

    localparam int c_gap_w = $clog2(GAP_CYC + 1);
    localparam int c_per_w = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
    localparam int c_to_w  = (BUSY_TO > 1) ? $clog2(BUSY_TO) : 1;
    localparam int c_rty_w = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [2:0] c_idle      = 3'd0;
    localparam logic [2:0] c_trig      = 3'd1;
    localparam logic [2:0] c_wait_busy = 3'd2;
    localparam logic [2:0] c_run       = 3'd3;
    localparam logic [2:0] c_done      = 3'd4;
    localparam logic [2:0] c_error     = 3'd5;

    logic [2:0]          r_state;
    logic [2:0]          w_state_nxt;
    logic [c_gap_w-1:0]  r_gap_cnt;
    logic [c_per_w-1:0]  r_per_cnt;
    logic [c_to_w-1:0]   r_to_cnt;
    logic [c_rty_w-1:0]  r_retry;
    logic [1:0]          r_idx;
    logic                r_err_lat;
    logic                r_pending;
    logic [VALUE_SZ-1:0] r_hum_sh;
    logic [VALUE_SZ-1:0] r_temp_sh;
    logic [VALUE_SZ-1:0] r_hum;
    logic [VALUE_SZ-1:0] r_temp;
    logic                r_en;
    logic                r_valid;
    logic                r_fail;
    logic                r_busy;
    logic [7:0]          r_err_cnt;

    logic w_to_hit;
    logic w_per_expire;
    logic w_retry_left;

    assign w_to_hit     = (r_to_cnt == c_to_w'(BUSY_TO - 1));
    assign w_per_expire = i_auto && (r_per_cnt == '0);
    assign w_retry_left = (32'(r_retry) < MAX_RETRY);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle: begin
                if (r_pending && (r_gap_cnt == '0)) begin
                    w_state_nxt = c_trig;
                end
            end
            c_trig: begin
                w_state_nxt = c_wait_busy;
            end
            c_wait_busy: begin
                if (i_busy) begin
                    w_state_nxt = c_run;
                end else if (w_to_hit) begin
                    w_state_nxt = c_error;
                end
            end
            c_run: begin
                // A fault reported in the very cycle busy drops still counts.
                if (!i_busy) begin
                    w_state_nxt = (!r_err_lat && !i_err && r_idx[1]) ? c_done : c_error;
                end
            end
            c_done:  w_state_nxt = c_idle;
            c_error: w_state_nxt = c_idle;
            default: w_state_nxt = c_idle;
        endcase
    end

    // Timers, request bookkeeping, capture and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gap_cnt <= c_gap_w'(GAP_CYC);
            r_per_cnt <= c_per_w'(PERIOD_CYC - 1);
            r_to_cnt  <= '0;
            r_retry   <= '0;
            r_idx     <= '0;
            r_err_lat <= 1'b0;
            r_pending <= 1'b0;
            r_hum_sh  <= '0;
            r_temp_sh <= '0;
            r_hum     <= '0;
            r_temp    <= '0;
            r_en      <= 1'b0;
            r_valid   <= 1'b0;
            r_fail    <= 1'b0;
            r_busy    <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            // o_en/o_busy follow the next state so they line up with TRIG
            r_en    <= (w_state_nxt == c_trig);
            r_busy  <= (w_state_nxt == c_trig) || (w_state_nxt == c_wait_busy) ||
                       (w_state_nxt == c_run);
            r_valid <= 1'b0;
            r_fail  <= 1'b0;

            if ((r_state == c_done) || (r_state == c_error)) begin
                r_gap_cnt <= c_gap_w'(GAP_CYC);
            end else if (r_gap_cnt != '0) begin
                r_gap_cnt <= r_gap_cnt - 1'b1;
            end

            if (!i_auto || (r_per_cnt == '0)) begin
                r_per_cnt <= c_per_w'(PERIOD_CYC - 1);
            end else begin
                r_per_cnt <= r_per_cnt - 1'b1;
            end

            // A new request in the TRIG cycle itself is kept for the next poll.
            if (r_state == c_trig) begin
                r_pending <= 1'b0;
            end
            if (i_start || w_per_expire || ((r_state == c_error) && w_retry_left)) begin
                r_pending <= 1'b1;
            end

            case (r_state)
                c_trig: begin
                    r_idx     <= '0;
                    r_err_lat <= 1'b0;
                    r_to_cnt  <= '0;
                end
                c_wait_busy: begin
                    if (!w_to_hit) begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                c_run: begin
                    if (i_conv) begin
                        case (r_idx)
                            2'd0:    r_hum_sh  <= i_value;
                            2'd1:    r_temp_sh <= i_value;
                            default: r_err_lat <= 1'b1;
                        endcase
                        if (!r_idx[1]) begin
                            r_idx <= r_idx + 2'd1;
                        end
                    end
                    if (i_err) begin
                        r_err_lat <= 1'b1;
                    end
                end
                c_done: begin
                    r_hum   <= r_hum_sh;
                    r_temp  <= r_temp_sh;
                    r_valid <= 1'b1;
                    r_retry <= '0;
                end
                c_error: begin
                    if (r_err_cnt != 8'hFF) begin
                        r_err_cnt <= r_err_cnt + 8'd1;
                    end
                    if (w_retry_left) begin
                        r_retry <= r_retry + 1'b1;
                    end else begin
                        r_fail  <= 1'b1;
                        r_retry <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_en      = r_en;
    assign o_busy    = r_busy;
    assign o_valid   = r_valid;
    assign o_fail    = r_fail;
    assign o_hum     = r_hum;
    assign o_temp    = r_temp;
    assign o_err_cnt = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dht11_poll_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dht11_poll_sched
//  Purpose  : Self-checking bench for dht11_poll_sched. A sensor responder
//             answers each trigger with a randomly chosen behaviour and a
//             transaction-level model predicts published values, pulse
//             counts and the error counter.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dht11_poll_sched;

    localparam int c_gap       = 100;
    localparam int c_period    = 1000;
    localparam int c_busy_to   = 50;
    localparam int c_max_retry = 2;

    localparam int c_k_good   = 0;
    localparam int c_k_nobusy = 1;
    localparam int c_k_errp   = 2;
    localparam int c_k_short  = 3;
    localparam int c_k_long   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_auto = 1'b0;
    logic        i_busy = 1'b0;
    logic        i_conv = 1'b0;
    logic        i_err = 1'b0;
    logic [15:0] i_value = '0;
    logic        o_en, o_valid, o_fail, o_busy;
    logic [15:0] o_hum, o_temp;
    logic [7:0]  o_err_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    // monitor observations
    int en_total = 0;
    int valid_cnt = 0;
    int fail_cnt = 0;
    int ref_cyc = 0;
    bit prev_en = 1'b0;
    bit prev_busy = 1'b0;

    // transaction-level model
    int          exp_en = 0;
    int          exp_valid = 0;
    int          exp_fail = 0;
    int          exp_err = 0;
    int          m_retry = 0;
    logic [15:0] exp_hum = '0;
    logic [15:0] exp_temp = '0;

    dht11_poll_sched #(
        .VALUE_SZ  (16),
        .GAP_CYC   (c_gap),
        .PERIOD_CYC(c_period),
        .BUSY_TO   (c_busy_to),
        .MAX_RETRY (c_max_retry)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .i_start  (i_start),
        .i_auto   (i_auto),
        .o_en     (o_en),
        .i_busy   (i_busy),
        .i_conv   (i_conv),
        .i_value  (i_value),
        .i_err    (i_err),
        .o_hum    (o_hum),
        .o_temp   (o_temp),
        .o_valid  (o_valid),
        .o_fail   (o_fail),
        .o_busy   (o_busy),
        .o_err_cnt(o_err_cnt)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Pulse-shape, exclusivity and inter-poll gap monitor
    always @(negedge clk) begin
        if (rst) begin
            ref_cyc = cyc;
        end else begin
            if (prev_busy && !o_busy) ref_cyc = cyc;
            if (o_en) begin
                check_eq("en_width", prev_en, 1'b0);
                check_eq("gap", (cyc - ref_cyc) >= c_gap, 1'b1);
                en_total++;
            end
            if (o_valid) valid_cnt++;
            if (o_fail) fail_cnt++;
            if (o_valid || o_fail) check_eq("valid_fail_excl", o_valid & o_fail, 1'b0);
        end
        prev_en   = o_en;
        prev_busy = o_busy;
    end

    task automatic pulse_start();
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_en(input int lim, output int at);
        int n = 0;
        while (!o_en && n < lim) begin
            @(negedge clk);
            n++;
        end
        at = cyc;
        check_eq("en_seen", o_en, 1'b1);
    endtask

    task automatic respond(input int kind, input logic [15:0] hv, input logic [15:0] tv);
        int nconv;
        if (kind == c_k_nobusy) return;
        nconv = (kind == c_k_short) ? 1 : (kind == c_k_long) ? 3 : 2;
        repeat ($urandom_range(1, 20)) @(negedge clk);
        i_busy = 1'b1;
        repeat ($urandom_range(2, 5)) @(negedge clk);
        for (int k = 0; k < nconv; k++) begin
            i_conv  = 1'b1;
            i_value = (k == 0) ? hv : (k == 1) ? tv : 16'($urandom);
            @(negedge clk);
            i_conv = 1'b0;
            repeat ($urandom_range(1, 4)) @(negedge clk);
        end
        if (kind == c_k_errp) begin
            i_err = 1'b1;
            @(negedge clk);
            i_err = 1'b0;
            @(negedge clk);
        end
        i_busy = 1'b0;
    endtask

    // One triggered attempt: respond, then compare against the model's outcome.
    task automatic attempt(input int kind, input logic [15:0] hv, input logic [15:0] tv,
                           output int en_at);
        int n = 0;
        int end_at;
        wait_en(c_gap + c_period + 100, en_at);
        check_eq("busy_on", o_busy, 1'b1);
        respond(kind, hv, tv);
        while (o_busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        end_at = cyc;
        check_eq("busy_end", o_busy, 1'b0);
        if (kind == c_k_nobusy)
            check_eq("timeout_lat", ((end_at - en_at) >= c_busy_to) &&
                                    ((end_at - en_at) <= c_busy_to + 3), 1'b1);
        repeat (3) @(negedge clk);

        exp_en++;
        if (kind == c_k_good) begin
            exp_valid++;
            exp_hum  = hv;
            exp_temp = tv;
            m_retry  = 0;
        end else begin
            if (exp_err < 255) exp_err++;
            if (m_retry < c_max_retry) begin
                m_retry++;
            end else begin
                exp_fail++;
                m_retry = 0;
            end
        end
        check_eq("en_count", en_total, exp_en);
        check_eq("valid_count", valid_cnt, exp_valid);
        check_eq("fail_count", fail_cnt, exp_fail);
        check_eq("err_cnt", o_err_cnt, 8'(exp_err));
        check_eq("hum", o_hum, exp_hum);
        check_eq("temp", o_temp, exp_temp);
    endtask

    initial begin
        int rel_at, t0, t1, t2, tx, kind;
        // reset state
        repeat (3) @(negedge clk);
        check_eq("reset_outs", {o_en, o_busy, o_valid, o_fail, o_err_cnt, o_hum, o_temp}, 44'd0);
        rst = 1'b0;
        rel_at = cyc;

        // manual request early after reset waits for the gap; good read
        repeat (10) @(negedge clk);
        pulse_start();
        attempt(c_k_good, 16'h3700, 16'h0019, t0);
        check_eq("first_trig_lat", ((t0 - rel_at) >= c_gap) && ((t0 - rel_at) <= c_gap + 4), 1'b1);

        // sensor never answers: two retries then a failure report
        pulse_start();
        for (int a = 0; a <= c_max_retry; a++) attempt(c_k_nobusy, 16'h0, 16'h0, tx);

        // fault pulse on the first try, good second try
        pulse_start();
        attempt(c_k_errp, 16'hAAAA, 16'h5555, tx);
        attempt(c_k_good, 16'h1234, 16'h0042, tx);

        // randomized requests
        for (int r = 0; r < 8; r++) begin
            repeat ($urandom_range(1, 30)) @(negedge clk);
            pulse_start();
            do begin
                kind = ($urandom_range(0, 1) == 0) ? c_k_good : int'($urandom_range(1, 4));
                attempt(kind, 16'($urandom), 16'($urandom), tx);
            end while (m_retry != 0);
        end

        // auto polling with a manual request coinciding with the first expiry
        repeat (150) @(negedge clk);
        i_auto = 1'b1;
        repeat (c_period - 1) @(negedge clk);
        pulse_start();
        attempt(c_k_good, 16'($urandom), 16'($urandom), t0);
        repeat (200) @(negedge clk);
        check_eq("coalesce", en_total, exp_en);
        attempt(c_k_good, 16'($urandom), 16'($urandom), t1);
        check_eq("period1", t1 - t0, c_period);
        attempt(c_k_good, 16'($urandom), 16'($urandom), t2);
        i_auto = 1'b0;
        check_eq("period2", t2 - t1, c_period);

        // reset in the middle of a read
        repeat (150) @(negedge clk);
        pulse_start();
        wait_en(400, tx);
        exp_en++;
        i_busy = 1'b1;
        repeat (3) @(negedge clk);
        i_conv  = 1'b1;
        i_value = 16'hBEEF;
        @(negedge clk);
        i_conv = 1'b0;
        @(negedge clk);
        check_eq("busy_pre_rst", o_busy, 1'b1);
        rst = 1'b1;
        #1;
        check_eq("rst_outs", {o_en, o_busy, o_valid, o_fail, o_err_cnt, o_hum, o_temp}, 44'd0);
        exp_err  = 0;
        exp_hum  = '0;
        exp_temp = '0;
        m_retry  = 0;
        i_busy   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rel_at = cyc;
        pulse_start();
        attempt(c_k_good, 16'h2A00, 16'h0017, t0);
        check_eq("post_rst_gap", (t0 - rel_at) >= c_gap, 1'b1);

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #(20 * 60000);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
